boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  - Host-side debug writer for the CPU's IM/DM debug-write port. Sits between a byte-stream link and the core.
//  - Parses load frames from the link and drives debug, address and data into the core to fill instruction or data memory.
//  - Holds the core in reset until a RUN frame arrives.
// PARAMETERS
//  TIMEOUT_CYC  1_000_000  max idle cycles between bytes inside a frame before abort (>=2)
//  SYNC_BYTE    8'hA5      frame start marker
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active high
//  rx_data    in   8   link byte
//  rx_valid   in   1   rx_data valid; byte consumed when rx_valid & rx_ready
//  rx_ready   out  1   loader can accept a byte this cycle
//  debug      out  1   high while loader owns the IM/DM debug-write port
//  dbg_addr   out  16  word address driven onto the core's debug address bus
//  dbg_wdata  out  16  word driven onto the core's debug write-data bus
//  im_we      out  1   1-cycle IM write strobe
//  dm_we      out  1   1-cycle DM write strobe
//  cpu_rst    out  1   hold core in reset (active high)
//  done       out  1   pulses 1 cycle after a frame completes cleanly
//  err        out  1   sticky error flag; cleared by next accepted SYNC_BYTE
// BEHAVIOUR
//  - Clock and reset: single clock. Reset is synchronous, active high.
//  - Reset values: rx_ready=1, debug=0, dbg_addr=0, dbg_wdata=0, im_we=0, dm_we=0, cpu_rst=1, done=0, err=0.
//  - Frame format (big-endian): SYNC, CMD, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x {DATA_H, DATA_L}, [CHK].
//  - CMD values:
//    - 8'h01: load IM.
//    - 8'h02: load DM.
//    - 8'h03: RUN. Frame ends after CMD; no ADDR/CNT/data fields.
//    - Any other value: sets err, returns to IDLE.
//  - FSM states: IDLE -> CMD -> ADDR_H -> ADDR_L -> CNT_H -> CNT_L -> DATA_H -> DATA_L -> WRITE -> (DATA_H | CHK | IDLE).
//  - IDLE: non-SYNC bytes are consumed and discarded.
//  - debug: rises on the cycle after a LOAD CMD is accepted. Falls on the cycle the frame ends or aborts.
//  - cpu_rst: stays 1 during every LOAD frame, so the core never executes mid-load.
//  - RUN: clears cpu_rst the cycle after CMD is accepted. cpu_rst returns to 1 when a new LOAD CMD is accepted or when rst is asserted.
//  - WRITE state (exactly 1 cycle):
//    - rx_ready=0.
//    - dbg_wdata = {DATA_H, DATA_L}, dbg_addr = current address.
//    - im_we or dm_we = 1, selected by CMD.
//    - Next cycle: address increments by 1; remaining count decrements by 1.
//  - Address is 16-bit and wraps 16'hFFFF -> 16'h0000 with no error.
//  - CNT == 0: the data phase is skipped, with no write strobes.
//  - Throughput: one word per 3 cycles minimum (2 byte beats + WRITE).
//  - Inter-byte timeout:
//    - Counter resets on every accepted byte and is inactive in IDLE.
//    - Reaching TIMEOUT_CYC: err=1, debug=0, return to IDLE. Words already written stay written.
//  - done pulses 1 cycle when a LOAD or RUN frame ends without error.
//  - SYNC_BYTE inside a frame is ordinary data, never a resync.
//  - rst asserted mid-frame: all state returns to reset values on the next edge. No partial strobe is issued.
// CONFIGURATION
//  - Macro BOOT_LOADER_CHKSUM_EN:
//    - Defined: LOAD frames carry a trailing CHK byte. CHK is the 8-bit XOR of every byte from CMD through the last DATA_L.
//      - Mismatch: err=1, no done pulse.
//      - Writes have already been issued; they are not rolled back.
//      - RUN frames carry no CHK.
//    - Undefined: no CHK byte; a frame ends after the last WRITE. The checksum logic is not compiled in.
// STRUCTURE
//  - boot_loader_pkg holds:
//    - State enum.
//    - SYNC default.
//    - CMD_LOAD_IM = 8'h01, CMD_LOAD_DM = 8'h02, CMD_RUN = 8'h03.
//  - Sub-module boot_loader_timer: inter-byte timeout counter.
//    - Inputs: clr, en. Output: expired.
//    - Width is $clog2(TIMEOUT_CYC+1).
//  - FSM, word assembly and checksum live in the top level.
// TESTING
//  1. Reset -> cpu_rst=1, debug=0, rx_ready=1, no strobes, err=0.
//  2. A5 01 00 10 00 02 12 34 AB CD [CHK=0x01^0x00^0x10^0x00^0x02^0x12^0x34^0xAB^0xCD]
//     -> im_we @ addr 0x0010 with 0x1234, im_we @ addr 0x0011 with 0xABCD.
//     -> done pulses once; debug spans the frame.
//  3. A5 02 FF FF 00 02 ... -> dm_we @ 0xFFFF, then @ 0x0000 (wrap). No err.
//  4. A5 03 -> cpu_rst falls 1 cycle after CMD; done pulses. A following A5 01 ... re-asserts cpu_rst.
//  5. Stall TIMEOUT_CYC cycles after ADDR_L -> err=1, debug=0, IDLE.
//     Next A5 clears err. Bad CMD 0x7E -> err=1.
//  6. Random rx_valid gaps and rst pulse mid-DATA_L
//     -> strobe count = completed words; outputs at reset values.
//     With CHKSUM_EN: corrupt CHK -> err=1, no done pulse.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding, default
// frame marker and command codes.
package boot_loader_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CMD    = 4'd1,
      S_ADDR_H = 4'd2,
      S_ADDR_L = 4'd3,
      S_CNT_H  = 4'd4,
      S_CNT_L  = 4'd5,
      S_DATA_H = 4'd6,
      S_DATA_L = 4'd7,
      S_WRITE  = 4'd8,
      S_CHK    = 4'd9
   } state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam logic [7:0] CMD_LOAD_IM  = 8'h01;
   localparam logic [7:0] CMD_LOAD_DM  = 8'h02;
   localparam logic [7:0] CMD_RUN      = 8'h03;

endpackage

// File: rtl/boot_loader_if.sv
// Link byte stream plus core debug-write port, as seen by the boot loader
// (master) and by the link/core side (slave).
interface boot_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        debug;
   logic [15:0] dbg_addr;
   logic [15:0] dbg_wdata;
   logic        im_we;
   logic        dm_we;
   logic        cpu_rst;
   logic        done;
   logic        err;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, debug, dbg_addr, dbg_wdata, im_we, dm_we, cpu_rst, done, err
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, debug, dbg_addr, dbg_wdata, im_we, dm_we, cpu_rst, done, err
   );
endinterface

// File: rtl/boot_loader_timer.sv
// Inter-byte timeout: down-counter reloaded on every accepted byte (or while
// disabled); expired is asserted once TIMEOUT_CYC idle cycles have elapsed.
module boot_loader_timer #(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYC + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= W'(TIMEOUT_CYC);
      end else if (clr || !en) begin
         cnt <= W'(TIMEOUT_CYC);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = en && (cnt == '0);

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses load/run frames and drives the core's IM/DM
// debug-write port. Optional trailing checksum: define BOOT_LOADER_CHKSUM_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for SYNC_BYTE, other bytes discarded
// CMD      | waiting for command byte
// ADDR_H/L | start word address, big-endian
// CNT_H/L  | word count, big-endian
// DATA_H/L | assembling one 16-bit data word
// WRITE    | one-cycle IM/DM write strobe, link stalled
// CHK      | waiting for XOR checksum byte (checksum build only)
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int         TIMEOUT_CYC = 1_000_000,
   parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   boot_loader_if.master bus
);

   state_t      state, state_d;
   logic        accept;
   logic        expired;
   logic        timer_en;
   logic        rx_ready_int;

   logic        cmd_dm;
   logic [15:0] addr;
   logic [15:0] cnt;
   logic [7:0]  data_h;
   logic [15:0] wdata;
   logic        cpu_rst_q;
   logic        done_q;
   logic        err_q;

   logic        set_err;
   logic        set_done;
   logic        clr_err;
   logic        load_go;
   logic        run_go;

`ifdef BOOT_LOADER_CHKSUM_EN
   logic [7:0]  chk;
`endif

   assign timer_en     = (state != S_IDLE);
   // No byte is taken in the abort cycle so it is not silently lost.
   assign rx_ready_int = (state != S_WRITE) && !expired;
   assign accept       = bus.rx_valid && rx_ready_int;

   boot_loader_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .en      (timer_en),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d  = state;
      set_err  = 1'b0;
      set_done = 1'b0;
      clr_err  = 1'b0;
      load_go  = 1'b0;
      run_go   = 1'b0;
      if (expired) begin
         state_d = S_IDLE;
         set_err = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && (bus.rx_data == SYNC_BYTE)) begin
                  state_d = S_CMD;
                  clr_err = 1'b1;
               end
            end
            S_CMD: begin
               if (accept) begin
                  case (bus.rx_data)
                     CMD_LOAD_IM, CMD_LOAD_DM: begin
                        state_d = S_ADDR_H;
                        load_go = 1'b1;
                     end
                     CMD_RUN: begin
                        state_d  = S_IDLE;
                        run_go   = 1'b1;
                        set_done = 1'b1;
                     end
                     default: begin
                        state_d = S_IDLE;
                        set_err = 1'b1;
                     end
                  endcase
               end
            end
            S_ADDR_H: if (accept) state_d = S_ADDR_L;
            S_ADDR_L: if (accept) state_d = S_CNT_H;
            S_CNT_H:  if (accept) state_d = S_CNT_L;
            S_CNT_L: begin
               if (accept) begin
                  if ({cnt[15:8], bus.rx_data} == 16'd0) begin
`ifdef BOOT_LOADER_CHKSUM_EN
                     state_d = S_CHK;
`else
                     state_d  = S_IDLE;
                     set_done = 1'b1;
`endif
                  end else begin
                     state_d = S_DATA_H;
                  end
               end
            end
            S_DATA_H: if (accept) state_d = S_DATA_L;
            S_DATA_L: if (accept) state_d = S_WRITE;
            S_WRITE: begin
               if (cnt == 16'd1) begin
`ifdef BOOT_LOADER_CHKSUM_EN
                  state_d = S_CHK;
`else
                  state_d  = S_IDLE;
                  set_done = 1'b1;
`endif
               end else begin
                  state_d = S_DATA_H;
               end
            end
`ifdef BOOT_LOADER_CHKSUM_EN
            S_CHK: begin
               if (accept) begin
                  state_d = S_IDLE;
                  if (bus.rx_data == chk) set_done = 1'b1;
                  else                    set_err  = 1'b1;
               end
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_dm    <= 1'b0;
         addr      <= 16'd0;
         cnt       <= 16'd0;
         data_h    <= 8'd0;
         wdata     <= 16'd0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= set_done;
         if (set_err)      err_q <= 1'b1;
         else if (clr_err) err_q <= 1'b0;
         if (load_go)      cpu_rst_q <= 1'b1;
         else if (run_go)  cpu_rst_q <= 1'b0;
         if (accept) begin
            case (state)
               S_CMD:    cmd_dm       <= (bus.rx_data == CMD_LOAD_DM);
               S_ADDR_H: addr[15:8]   <= bus.rx_data;
               S_ADDR_L: addr[7:0]    <= bus.rx_data;
               S_CNT_H:  cnt[15:8]    <= bus.rx_data;
               S_CNT_L:  cnt[7:0]     <= bus.rx_data;
               S_DATA_H: data_h       <= bus.rx_data;
               S_DATA_L: wdata        <= {data_h, bus.rx_data};
               default:  ;
            endcase
         end
         // Address wraps naturally at 16 bits.
         if (state == S_WRITE) begin
            addr <= addr + 16'd1;
            cnt  <= cnt - 16'd1;
         end
      end
   end

`ifdef BOOT_LOADER_CHKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         chk <= 8'd0;
      end else if (accept) begin
         case (state)
            S_IDLE:  chk <= 8'd0;
            S_CMD, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L:
                     chk <= chk ^ bus.rx_data;
            default: ;
         endcase
      end
   end
`endif

   assign bus.rx_ready  = rx_ready_int;
   assign bus.debug     = (state != S_IDLE) && (state != S_CMD);
   assign bus.dbg_addr  = addr;
   assign bus.dbg_wdata = wdata;
   // Strobes are masked during reset so a WRITE cut short never reaches memory.
   assign bus.im_we     = (state == S_WRITE) && !cmd_dm && !rst;
   assign bus.dm_we     = (state == S_WRITE) &&  cmd_dm && !rst;
   assign bus.cpu_rst   = cpu_rst_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of frames plus hand-written sequences
// for run timing, timeout, reset mid-frame and (optionally) bad checksum.
module tb_boot_loader;
   import boot_loader_pkg::*;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   boot_loader_if bus();

   boot_loader #(
      .TIMEOUT_CYC (TO),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        dm;
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t wq[$];
   int  done_cnt = 0;

   typedef struct {
      string       name;
      logic [7:0]  cmd;
      logic [15:0] addr;
      logic [15:0] cnt;
      logic [15:0] d0;
      logic [15:0] d1;
      int          junk;
      int          gapmax;
      int          exp_n;
      logic        exp_dm;
      logic [15:0] ea0;
      logic [15:0] ed0;
      logic [15:0] ea1;
      logic [15:0] ed1;
      int          exp_done;
      logic        exp_err;
      logic        exp_cpu_rst;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Write and done monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.im_we || bus.dm_we) begin
            wq.push_back('{dm: bus.dm_we, addr: bus.dbg_addr, data: bus.dbg_wdata});
            checks++;
            if (!bus.debug || !bus.cpu_rst || (bus.im_we && bus.dm_we)) begin
               errors++;
               $display("FAIL strobe_ctx: debug=%0b cpu_rst=%0b im_we=%0b dm_we=%0b required debug=1 cpu_rst=1 one strobe",
                        bus.debug, bus.cpu_rst, bus.im_we, bus.dm_we);
            end
         end
         if (bus.done) done_cnt++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic acc;
      acc = 1'b0;
      bus.rx_valid = 1'b0;
      if (gap > 0) idle(gap);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         acc = bus.rx_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      bus.rx_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte 0x%0h not accepted within 64 cycles", b);
      end
   endtask

   task automatic send_seq(input logic [7:0] q[$], input int gapmax);
      foreach (q[i]) send_byte(q[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
   endtask

   function automatic vec_t mkv(input string n, input logic [7:0] cmd, input logic [15:0] addr,
                                input logic [15:0] cnt, input logic [15:0] d0, input logic [15:0] d1,
                                input int junk, input int gapmax, input int exp_n, input logic exp_dm,
                                input logic [15:0] ea0, input logic [15:0] ed0,
                                input logic [15:0] ea1, input logic [15:0] ed1,
                                input int exp_done, input logic exp_err, input logic exp_cpu_rst);
      vec_t v;
      v.name = n; v.cmd = cmd; v.addr = addr; v.cnt = cnt; v.d0 = d0; v.d1 = d1;
      v.junk = junk; v.gapmax = gapmax; v.exp_n = exp_n; v.exp_dm = exp_dm;
      v.ea0 = ea0; v.ed0 = ed0; v.ea1 = ea1; v.ed1 = ed1;
      v.exp_done = exp_done; v.exp_err = exp_err; v.exp_cpu_rst = exp_cpu_rst;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      logic [7:0] q[$];
      int         first;
      logic [7:0] x;
      wq.delete();
      done_cnt = 0;
      if (v.junk != 0) begin
         q.push_back(8'h00);
         q.push_back(8'h3C);
      end
      q.push_back(8'hA5);
      first = q.size();
      q.push_back(v.cmd);
      if (v.cmd == 8'h01 || v.cmd == 8'h02) begin
         q.push_back(v.addr[15:8]); q.push_back(v.addr[7:0]);
         q.push_back(v.cnt[15:8]);  q.push_back(v.cnt[7:0]);
         if (v.cnt >= 16'd1) begin q.push_back(v.d0[15:8]); q.push_back(v.d0[7:0]); end
         if (v.cnt >= 16'd2) begin q.push_back(v.d1[15:8]); q.push_back(v.d1[7:0]); end
`ifdef BOOT_LOADER_CHKSUM_EN
         x = 8'h00;
         for (int i = first; i < q.size(); i++) x = x ^ q[i];
         q.push_back(x);
`else
         x = 8'h00;
`endif
      end
      send_seq(q, v.gapmax);
      idle(4);
      check({v.name, ".nwr"}, 32'(wq.size()), 32'(v.exp_n));
      for (int i = 0; i < v.exp_n && i < wq.size(); i++) begin
         check({v.name, ".dm"},   32'(wq[i].dm),   32'(v.exp_dm));
         check({v.name, ".addr"}, 32'(wq[i].addr), 32'((i == 0) ? v.ea0 : v.ea1));
         check({v.name, ".data"}, 32'(wq[i].data), 32'((i == 0) ? v.ed0 : v.ed1));
      end
      check({v.name, ".done"},    32'(done_cnt),    32'(v.exp_done));
      check({v.name, ".err"},     32'(bus.err),     32'(v.exp_err));
      check({v.name, ".cpu_rst"}, 32'(bus.cpu_rst), 32'(v.exp_cpu_rst));
      check({v.name, ".debug"},   32'(bus.debug),   32'd0);
   endtask

   task automatic check_reset_vals(input string n);
      check({n, ".rx_ready"},  32'(bus.rx_ready),  32'd1);
      check({n, ".debug"},     32'(bus.debug),     32'd0);
      check({n, ".dbg_addr"},  32'(bus.dbg_addr),  32'd0);
      check({n, ".dbg_wdata"}, 32'(bus.dbg_wdata), 32'd0);
      check({n, ".im_we"},     32'(bus.im_we),     32'd0);
      check({n, ".dm_we"},     32'(bus.dm_we),     32'd0);
      check({n, ".cpu_rst"},   32'(bus.cpu_rst),   32'd1);
      check({n, ".done"},      32'(bus.done),      32'd0);
      check({n, ".err"},       32'(bus.err),       32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;

      vecs[0] = mkv("im2",     8'h01, 16'h0010, 16'd2, 16'h1234, 16'hABCD, 0, 0,
                    2, 1'b0, 16'h0010, 16'h1234, 16'h0011, 16'hABCD, 1, 1'b0, 1'b1);
      vecs[1] = mkv("dm_wrap", 8'h02, 16'hFFFF, 16'd2, 16'hBEEF, 16'h0102, 0, 2,
                    2, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 16'h0102, 1, 1'b0, 1'b1);
      vecs[2] = mkv("cnt0",    8'h01, 16'h0100, 16'd0, 16'h0000, 16'h0000, 0, 1,
                    0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 1'b1);
      vecs[3] = mkv("run",     8'h03, 16'h0000, 16'd0, 16'h0000, 16'h0000, 0, 0,
                    0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
      vecs[4] = mkv("im1",     8'h01, 16'h0200, 16'd1, 16'h5A5A, 16'h0000, 0, 3,
                    1, 1'b0, 16'h0200, 16'h5A5A, 16'h0000, 16'h0000, 1, 1'b0, 1'b1);
      vecs[5] = mkv("badcmd",  8'h7E, 16'h0000, 16'd0, 16'h0000, 16'h0000, 0, 0,
                    0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1, 1'b1);
      vecs[6] = mkv("syncdat", 8'h01, 16'h0020, 16'd1, 16'hA5A5, 16'h0000, 1, 2,
                    1, 1'b0, 16'h0020, 16'hA5A5, 16'h0000, 16'h0000, 1, 1'b0, 1'b1);
      vecs[7] = mkv("run2",    8'h03, 16'h0000, 16'd0, 16'h0000, 16'h0000, 1, 2,
                    0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);

      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      check_reset_vals("reset");

      // RUN: cpu_rst drops and done pulses the cycle after CMD is taken.
      send_byte(8'hA5, 0);
      check("run_t.cpu_rst_pre", 32'(bus.cpu_rst), 32'd1);
      send_byte(8'h03, 0);
      check("run_t.cpu_rst", 32'(bus.cpu_rst), 32'd0);
      check("run_t.done",    32'(bus.done),    32'd1);
      idle(1);
      check("run_t.done_off", 32'(bus.done),   32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // LOAD CMD re-asserts cpu_rst and raises debug on the next cycle.
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      check("load_t.cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check("load_t.debug",   32'(bus.debug),   32'd1);

      // Stall after ADDR_L until the inter-byte timeout fires.
      send_byte(8'h00, 0);
      send_byte(8'h10, 0);
      repeat (TO - 2) @(posedge clk);
      #1;
      check("tmo.err_early",   32'(bus.err),   32'd0);
      check("tmo.debug_early", 32'(bus.debug), 32'd1);
      idle(5);
      check("tmo.err",   32'(bus.err),   32'd1);
      check("tmo.debug", 32'(bus.debug), 32'd0);
      send_byte(8'hA5, 0);
      check("tmo.err_clr", 32'(bus.err), 32'd0);
      send_byte(8'h7E, 0);
      check("bad7e.err", 32'(bus.err), 32'd1);
      idle(2);

      // Reset while waiting for DATA_L of the second word.
      wq.delete();
      q = '{8'hA5, 8'h01, 8'h00, 8'h40, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
      send_seq(q, 2);
      idle(1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_reset_vals("midrst");
      idle(3);
      check("midrst.nwr", 32'(wq.size()), 32'd1);
      if (wq.size() > 0) begin
         check("midrst.addr", 32'(wq[0].addr), 32'h0040);
         check("midrst.data", 32'(wq[0].data), 32'h1122);
      end

`ifdef BOOT_LOADER_CHKSUM_EN
      // Corrupt checksum: write still lands, err set, no done.
      wq.delete();
      done_cnt = 0;
      q = '{8'hA5, 8'h01, 8'h00, 8'h50, 8'h00, 8'h01, 8'h12, 8'h34};
      q.push_back((8'h01 ^ 8'h00 ^ 8'h50 ^ 8'h00 ^ 8'h01 ^ 8'h12 ^ 8'h34) ^ 8'hFF);
      send_seq(q, 1);
      idle(4);
      check("badchk.nwr",  32'(wq.size()), 32'd1);
      check("badchk.err",  32'(bus.err),   32'd1);
      check("badchk.done", 32'(done_cnt),  32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
